// File: rtl/flash_pkg.sv
// Shared types and constants for the flash weight responder.
package flash_pkg;

    localparam int unsigned FLASH_DATA_W      = 16;
    localparam int unsigned FLASH_ADDR_W      = 16;
    localparam int unsigned FLASH_DEF_LATENCY = 10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } flash_state_t;

    // Even parity bit: set so that the word plus this bit has an even number of ones.
    function automatic logic even_parity(input logic [FLASH_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Up counter with synchronous clear, enable and programmable rollover value.
// On reaching rollover_val while enabled the count wraps to 1.
// rollover_flag is registered and is high while count_out equals rollover_val.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    flag_q, flag_d;

    // Next count: clear wins over enable; wrap to 1 after the rollover value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = NUM_CNT_BITS'(1);
            end else begin
                count_d = count_q + NUM_CNT_BITS'(1);
            end
        end
        flag_d = (count_d == rollover_val);
    end

    // Count and flag registers.
    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = flag_q;

endmodule

// File: rtl/flash_weight_responder.sv
// Responder end of the weight/bias flash read protocol.
// A one-cycle flash_ready request is answered LATENCY+1 cycles later with a one-cycle data_valid
// pulse; flashData_out is registered and held until the next response. The backing word array is
// written through the prog_* port and is not reset.
// Build option: define FLASH_PARITY_EN to store an even-parity bit per word, check it on every
// response and expose the parity_err port.
module flash_weight_responder
    import flash_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LATENCY = FLASH_DEF_LATENCY
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    flash_ready,
    input  logic [FLASH_ADDR_W-1:0] flash_address,
    output logic [FLASH_DATA_W-1:0] flashData_out,
    output logic                    data_valid,
    output logic                    busy,
    output logic                    overrun,
    output logic                    addr_err,
    input  logic                    prog_en,
    input  logic [ADDR_W-1:0]       prog_addr,
    input  logic [FLASH_DATA_W-1:0] prog_data
`ifdef FLASH_PARITY_EN
    ,
    output logic                    parity_err
`endif
);

    localparam int unsigned CntW = $clog2(LATENCY + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(LATENCY - 1);

`ifdef FLASH_PARITY_EN
    localparam int unsigned MemW = FLASH_DATA_W + 1;
`else
    localparam int unsigned MemW = FLASH_DATA_W;
`endif

    logic [MemW-1:0] mem_q [DEPTH];

    flash_state_t            state_q;
    logic [FLASH_ADDR_W-1:0] addr_q;
    logic [FLASH_DATA_W-1:0] data_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    overrun_q;
    logic                    addr_err_q;

    logic                    accept;
    logic                    cnt_en;
    logic                    wait_done;
    logic [CntW-1:0]         cnt;
    logic                    cnt_flag;

    logic [MemW-1:0]         wr_word;
    logic [ADDR_W-1:0]       rd_idx;
    logic [MemW-1:0]         rd_word;
    logic                    rd_err;
    logic [FLASH_DATA_W-1:0] rd_data;

`ifdef FLASH_PARITY_EN
    logic                    parity_err_q;
    logic                    rd_perr;
`endif

    // Request is taken when idle, or back-to-back in the response cycle.
    always_comb begin
        accept    = flash_ready && ((state_q == IDLE) || (state_q == RESPOND));
        cnt_en    = (state_q == WAIT);
        // The registered flag tracks the count; requiring both keeps the exit tied to the count.
        wait_done = cnt_flag && (cnt == LastCnt);
    end

    flex_counter #(
        .NUM_CNT_BITS (CntW)
    ) u_lat_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (accept),
        .count_enable  (cnt_en),
        .rollover_val  (LastCnt),
        .count_out     (cnt),
        .rollover_flag (cnt_flag)
    );

    // Word as stored: optionally prefixed by its even-parity bit.
    always_comb begin
`ifdef FLASH_PARITY_EN
        wr_word = {even_parity(prog_data), prog_data};
`else
        wr_word = prog_data;
`endif
    end

    // Program port; storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (prog_en) begin
            mem_q[prog_addr] <= wr_word;
        end
    end

    // Fetch for the response. Out-of-range addresses (upper bits set or index past DEPTH)
    // return zero and raise addr_err.
    always_comb begin
        rd_idx  = addr_q[ADDR_W-1:0];
        rd_err  = ((addr_q >> ADDR_W) != '0) || (32'(rd_idx) >= DEPTH);
        rd_word = mem_q[rd_idx];
        rd_data = rd_err ? '0 : rd_word[FLASH_DATA_W-1:0];
`ifdef FLASH_PARITY_EN
        rd_perr = !rd_err && (even_parity(rd_word[FLASH_DATA_W-1:0]) != rd_word[FLASH_DATA_W]);
`endif
    end

    // Request FSM with registered outputs. The array is sampled on the edge entering RESPOND,
    // so a write committing on that same edge is not seen (read-before-write).
    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            addr_err_q   <= 1'b0;
`ifdef FLASH_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            addr_err_q   <= 1'b0;
`ifdef FLASH_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= flash_address;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // A request while busy is dropped; the one in flight continues.
                    if (flash_ready) begin
                        overrun_q <= 1'b1;
                    end
                    if (wait_done) begin
                        data_q       <= rd_data;
                        valid_q      <= 1'b1;
                        addr_err_q   <= rd_err;
`ifdef FLASH_PARITY_EN
                        parity_err_q <= rd_perr;
`endif
                        busy_q       <= 1'b0;
                        state_q      <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (accept) begin
                        addr_q  <= flash_address;
                        busy_q  <= 1'b1;
                        state_q <= WAIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign flashData_out = data_q;
    assign data_valid    = valid_q;
    assign busy          = busy_q;
    assign overrun       = overrun_q;
    assign addr_err      = addr_err_q;
`ifdef FLASH_PARITY_EN
    assign parity_err    = parity_err_q;
`endif

endmodule
